// File: rtl/mux_scan_nx1_pkg.sv
// Shared types and constants for the mux_scan_nx1 selector.
// Holds the FSM state encodings and the mode input constants.
package mux_scan_nx1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_e;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int DWELL_CW = 8;

endpackage

// File: rtl/mux_scan_nx1_core.sv
// mux_nx1_core: purely combinational W-bit N:1 select.
// Ports: din (NCH*W, channel k at din[k*W +: W]), sel (channel), y (selected word).
module mux_nx1_core
    import mux_scan_nx1_pkg::*;
#(
    parameter int NCH = 7,
    parameter int W = 1,
    localparam int SELW = $clog2(NCH)
) (
    input  logic [NCH*W-1:0] din,
    input  logic [SELW-1:0]  sel,
    output logic [W-1:0]     y
);

    always_comb begin
        y = '0;
        for (int k = 0; k < NCH; k++) begin
            if (int'(sel) == k) begin
                y = din[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_scan_nx1.sv
// mux_scan_nx1: N-channel W-bit selector, registered output, valid/ready out.
// Modes: MANUAL (channel loaded from sel_in) and SCAN (auto-rotating, DWELL
// accepted samples per channel). Invalid selects pulse sel_err.
// Ports: clk, rst_n (async, active-low), mode, sel_in, sel_load, din,
// out_ready -> out_valid, dout, dout_ch, sel_err.
// Macro MUX_SCAN_MASK_EN adds ch_mask [NCH-1:0] (1 = channel enabled).
module mux_scan_nx1
    import mux_scan_nx1_pkg::*;
#(
    parameter int NCH = 7,
    parameter int W = 1,
    parameter int DWELL = 4,
    localparam int SELW = $clog2(NCH)
) (
`ifdef MUX_SCAN_MASK_EN
    input  logic [NCH-1:0]   ch_mask,
`endif
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [SELW-1:0]  sel_in,
    input  logic             sel_load,
    input  logic [NCH*W-1:0] din,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [W-1:0]     dout,
    output logic [SELW-1:0]  dout_ch,
    output logic             sel_err
);

    // Enable vector padded to every encodable select code, so codes
    // >= NCH read as disabled and double as the range check.
    localparam int NSEL = 2 ** SELW;

    logic [NCH-1:0]  en;
    logic [NSEL-1:0] en_x;

`ifdef MUX_SCAN_MASK_EN
    assign en = ch_mask;
`else
    assign en = '1;
`endif
    assign en_x = NSEL'(en);

    // Nearest enabled channel after c, wrapping; c itself if none.
    function automatic logic [SELW-1:0] next_en(
        input logic [SELW-1:0] c,
        input logic [NCH-1:0]  m
    );
        logic [SELW-1:0] r;
        int              idx;
        r = c;
        for (int i = NCH - 1; i >= 1; i--) begin
            idx = (int'(c) + i) % NCH;
            if (m[idx]) r = idx[SELW-1:0];
        end
        return r;
    endfunction

    state_e               state_q, state_d;
    logic [SELW-1:0]      cur_q, cur_d;
    logic [DWELL_CW-1:0]  dwell_q, dwell_d;
    logic                 valid_q, valid_d;
    logic [W-1:0]         dout_q, dout_d;
    logic [SELW-1:0]      ch_q, ch_d;
    logic                 err_q, err_d;

    logic            in_scan;
    logic            cap;
    logic [SELW-1:0] cap_ch;
    logic [W-1:0]    mux_y;

    mux_nx1_core #(
        .NCH (NCH),
        .W   (W)
    ) u_core (
        .din (din),
        .sel (cap_ch),
        .y   (mux_y)
    );

    always_comb begin
        state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
        in_scan = (state_q == ST_SCAN);

        // SCAN skips forward off a disabled channel before sampling.
        cap_ch = cur_q;
        if (in_scan && !en_x[cur_q]) cap_ch = next_en(cur_q, en);

        cap = (!valid_q || out_ready) && (state_q != ST_IDLE)
              && (!in_scan || (|en));

        cur_d   = cur_q;
        dwell_d = dwell_q;
        valid_d = valid_q;
        dout_d  = dout_q;
        ch_d    = ch_q;
        err_d   = 1'b0;

        if (cap) begin
            dout_d  = mux_y;
            ch_d    = cap_ch;
            valid_d = 1'b1;
            if (in_scan) begin
                if (int'(dwell_q) + 1 >= DWELL) begin
                    dwell_d = '0;
                    cur_d   = next_en(cap_ch, en);
                end else begin
                    dwell_d = dwell_q + 1'b1;
                    cur_d   = cap_ch;
                end
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end

        if (sel_load && state_q == ST_MANUAL) begin
            if (en_x[sel_in]) cur_d = sel_in;
            else              err_d = 1'b1;
        end

        if (state_q != ST_SCAN && state_d == ST_SCAN) dwell_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            dwell_q <= '0;
            valid_q <= 1'b0;
            dout_q  <= '0;
            ch_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            dwell_q <= dwell_d;
            valid_q <= valid_d;
            dout_q  <= dout_d;
            ch_q    <= ch_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign dout      = dout_q;
    assign dout_ch   = ch_q;
    assign sel_err   = err_q;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Self-checking bench for mux_scan_nx1 (NCH=7, W=8, DWELL=2).
// Define MUX_SCAN_MASK_EN to also exercise the channel-mask feature.
module tb_mux_scan_nx1;

    localparam int NCH = 7;
    localparam int W = 8;
    localparam int DWELL = 2;
    localparam int SELW = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             mode = 1'b0;
    logic [SELW-1:0]  sel_in = '0;
    logic             sel_load = 1'b0;
    logic [NCH*W-1:0] din = '0;
    logic             out_ready = 1'b0;
    logic [NCH-1:0]   ch_mask = '1;
    logic             out_valid;
    logic [W-1:0]     dout;
    logic [SELW-1:0]  dout_ch;
    logic             sel_err;

    int total = 0;
    int passed = 0;

    int              k_cap;
    logic            e_valid;
    logic [W-1:0]    e_dout;
    logic [SELW-1:0] e_ch;

    always #5 clk = ~clk;

    mux_scan_nx1 #(
        .NCH   (NCH),
        .W     (W),
        .DWELL (DWELL)
    ) dut (
`ifdef MUX_SCAN_MASK_EN
        .ch_mask   (ch_mask),
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel_in    (sel_in),
        .sel_load  (sel_load),
        .din       (din),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .dout      (dout),
        .dout_ch   (dout_ch),
        .sel_err   (sel_err)
    );

    // Channel of the k-th accepted SCAN sample: each enabled channel in
    // ascending order gets DWELL samples, then the list repeats.
    function automatic int scan_ch(input int k, input logic [NCH-1:0] m);
        int lst[$];
        for (int c = 0; c < NCH; c++) if (m[c]) lst.push_back(c);
        return lst[(k / DWELL) % lst.size()];
    endfunction

    task automatic rand_din();
        for (int c = 0; c < NCH; c++) din[c*W +: W] = W'($urandom);
    endtask

    task automatic do_reset(input logic m);
        rst_n = 1'b0;
        mode = m;
        sel_load = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        k_cap = 0;
        e_valid = 1'b0;
        e_dout = '0;
        e_ch = '0;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        total++;
        if ({out_valid, dout, dout_ch, sel_err} !== '0) begin
            $display("FAIL reset_state got v=%b d=%h ch=%0d e=%b want 0",
                     out_valid, dout, dout_ch, sel_err);
        end else passed++;
        rst_n = 1'b1;
        out_ready = 1'b1;
        rand_din();
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b1) begin
            $display("FAIL scan_active got v=%b want 1", out_valid);
        end else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({out_valid, dout, dout_ch, sel_err} !== '0) begin
            $display("FAIL async_reset got v=%b d=%h ch=%0d e=%b want 0",
                     out_valid, dout, dout_ch, sel_err);
        end else passed++;
    endtask

    task automatic test_manual();
        int c;
        int prev;
        logic [W-1:0] want;
        do_reset(1'b0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rand_din();
            c = (i == 4) ? 5 : $urandom_range(0, NCH - 1);
            if (i == 4) din[5*W +: W] = 8'hA5;
            sel_in = SELW'(c);
            sel_load = 1'b1;
            @(posedge clk);
            #1;
            want = din[prev*W +: W];
            total++;
            if (dout_ch !== SELW'(prev) || dout !== want) begin
                $display("FAIL manual_old_ch got ch=%0d d=%h want ch=%0d d=%h",
                         dout_ch, dout, prev, want);
            end else passed++;
            @(negedge clk);
            sel_load = 1'b0;
            @(posedge clk);
            #1;
            want = din[c*W +: W];
            total++;
            if (dout_ch !== SELW'(c) || dout !== want || out_valid !== 1'b1) begin
                $display("FAIL manual_new_ch got ch=%0d d=%h v=%b want ch=%0d d=%h v=1",
                         dout_ch, dout, out_valid, c, want);
            end else passed++;
            prev = c;
        end
    endtask

    task automatic test_invalid();
        @(negedge clk);
        sel_in = 3'd7;
        sel_load = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (sel_err !== 1'b1) begin
            $display("FAIL sel_err_pulse got %b want 1", sel_err);
        end else passed++;
        @(negedge clk);
        sel_load = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (sel_err !== 1'b0 || dout_ch !== 3'd5) begin
            $display("FAIL sel_err_clear got e=%b ch=%0d want e=0 ch=5",
                     sel_err, dout_ch);
        end else passed++;
        @(negedge clk);
        mode = 1'b1;
        @(negedge clk);
        sel_in = 3'd7;
        sel_load = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (sel_err !== 1'b0) begin
            $display("FAIL scan_ignores_load got e=%b want 0", sel_err);
        end else passed++;
        @(negedge clk);
        sel_load = 1'b0;
    endtask

    task automatic test_scan();
        logic [NCH*W-1:0] d;
        int c;
        do_reset(1'b1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            $display("FAIL scan_first_edge got v=%b want 0", out_valid);
        end else passed++;
        for (int i = 0; i < 2 * NCH + 2; i++) begin
            @(negedge clk);
            rand_din();
            out_ready = 1'b1;
            d = din;
            @(posedge clk);
            #1;
            c = scan_ch(k_cap, ch_mask);
            e_dout = d[c*W +: W];
            e_ch = SELW'(c);
            e_valid = 1'b1;
            k_cap++;
            total++;
            if (dout_ch !== e_ch || dout !== e_dout || out_valid !== 1'b1) begin
                $display("FAIL scan_seq[%0d] got ch=%0d d=%h v=%b want ch=%0d d=%h v=1",
                         i, dout_ch, dout, out_valid, e_ch, e_dout);
            end else passed++;
        end
    endtask

    task automatic test_backpressure();
        logic [NCH*W-1:0] d;
        logic r;
        int c;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rand_din();
            r = (i < 3) ? 1'b0 : 1'($urandom_range(0, 1));
            out_ready = r;
            d = din;
            @(posedge clk);
            #1;
            if (!e_valid || r) begin
                c = scan_ch(k_cap, ch_mask);
                e_dout = d[c*W +: W];
                e_ch = SELW'(c);
                e_valid = 1'b1;
                k_cap++;
            end
            total++;
            if (dout_ch !== e_ch || dout !== e_dout || out_valid !== e_valid) begin
                $display("FAIL backpressure[%0d] got ch=%0d d=%h v=%b want ch=%0d d=%h v=%b",
                         i, dout_ch, dout, out_valid, e_ch, e_dout, e_valid);
            end else passed++;
        end
    endtask

`ifdef MUX_SCAN_MASK_EN
    task automatic test_mask();
        logic [NCH*W-1:0] d;
        int c;
        ch_mask = 7'b0010010;
        do_reset(1'b1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rand_din();
            d = din;
            @(posedge clk);
            #1;
            c = scan_ch(k_cap, ch_mask);
            e_dout = d[c*W +: W];
            e_ch = SELW'(c);
            k_cap++;
            total++;
            if (dout_ch !== e_ch || dout !== e_dout) begin
                $display("FAIL mask_seq[%0d] got ch=%0d d=%h want ch=%0d d=%h",
                         i, dout_ch, dout, e_ch, e_dout);
            end else passed++;
        end
        @(negedge clk);
        ch_mask = '0;
        out_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || dout_ch !== e_ch) begin
                $display("FAIL mask_zero_hold got v=%b ch=%0d want v=1 ch=%0d",
                         out_valid, dout_ch, e_ch);
            end else passed++;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            $display("FAIL mask_zero_drain got v=%b want 0", out_valid);
        end else passed++;
        ch_mask = '1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_manual();
        test_invalid();
        test_scan();
        test_backpressure();
`ifdef MUX_SCAN_MASK_EN
        test_mask();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
